// File: rtl/rk_step_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// rk_sched_pkg
// Shared types and constants for the RK step scheduler:
//   state_t   - scheduler FSM states with a fixed 2-bit encoding
//   *_DEF     - default widths / divisor / watchdog limit
//   sat_inc() - saturating increment used by the overrun counter
// Optional build macro used by the slice: STEP_TIMEOUT_EN (step watchdog).
// ---------------------------------------------------------------------------
package rk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        REQ   = 2'b10
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int DIV_DEFAULT_DEF = 9999;
    localparam int OVR_W_DEF       = 8;
    localparam int TIMEOUT_DEF     = 4095;

    // Increment v, sticking at vmax. Callers zero-extend narrower counters
    // to 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] vmax);
        return (v >= vmax) ? vmax : v + 32'd1;
    endfunction

endpackage

// File: rtl/rk_step_scheduler_if.sv
// ---------------------------------------------------------------------------
// rk_step_scheduler_if
// Control / handshake bundle between board controls + RK engine (master)
// and the step scheduler (slave).
//   divisor, load      - prescaler reload
//   run, single        - continuous / one-shot stepping controls
//   step_req/step_done - request/completion handshake with the RK engine
//   tick, busy         - observation
//   overrun_cnt        - saturating count of ticks missed during a request
//   timeout            - watchdog abort pulse (0 unless STEP_TIMEOUT_EN)
// ---------------------------------------------------------------------------
interface rk_step_scheduler_if #(
    parameter int CNT_W = 16,
    parameter int OVR_W = 8
);
    logic [CNT_W-1:0] divisor;
    logic             load;
    logic             run;
    logic             single;
    logic             step_req;
    logic             step_done;
    logic             tick;
    logic             busy;
    logic [OVR_W-1:0] overrun_cnt;
    logic             timeout;

    modport master (
        output divisor, load, run, single, step_done,
        input  step_req, tick, busy, overrun_cnt, timeout
    );

    modport slave (
        input  divisor, load, run, single, step_done,
        output step_req, tick, busy, overrun_cnt, timeout
    );
endinterface

// File: rtl/rk_step_scheduler_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Programmable rate divider producing a one-cycle tick every div_q+1
// enabled cycles.
//   clockin - system clock          reset   - sync, active-high
//   en      - count enable; count is held at 0 while low
//   load    - latch divisor into div_q and restart the count (no tick)
//   divisor - new terminal count
//   tick    - high for the cycle in which count == div_q
//   count   - current count, for observation
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 9999
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] divisor,
    output logic             tick,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_div_q;
    logic [CNT_W-1:0] r_count;
    logic             w_term;

    assign w_term = (r_count == r_div_q);
    // a reload restarts the period, so the terminal cycle is swallowed
    assign tick   = en && !load && w_term;
    assign count  = r_count;

    always_ff @(posedge clockin) begin
        if (reset) begin
            r_div_q <= CNT_W'(DIV_DEFAULT);
            r_count <= '0;
        end else if (load) begin
            r_div_q <= divisor;
            r_count <= '0;
        end else if (!en || w_term) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/rk_step_scheduler.sv
// ---------------------------------------------------------------------------
// rk_step_scheduler
// Paces the RK step engine from the free-running system clock: a prescaler
// produces rate ticks and a small FSM turns each tick (or a single-step
// strobe) into a step_req/step_done handshake.
//   clockin - system clock (rising edge)
//   reset   - synchronous, active-high
//   bus     - rk_step_scheduler_if.slave (controls, handshake, status)
// Build macro: STEP_TIMEOUT_EN adds a watchdog that aborts a request after
// TIMEOUT cycles in REQ without step_done.
// ---------------------------------------------------------------------------
module rk_step_scheduler
    import rk_sched_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
    parameter int OVR_W       = OVR_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                 clockin,
    input  logic                 reset,
    rk_step_scheduler_if.slave   bus
);
    state_t           r_state;
    state_t           w_next;
    logic             r_step_req;
    logic [OVR_W-1:0] r_ovr;
    logic             w_tick;
    logic             w_busy;
    logic             w_ovr_inc;
    logic             w_timeout;
    logic             w_wd_exp;
    logic [CNT_W-1:0] w_count_unused;  // prescaler count is debug-only here

    tick_prescaler #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_prescaler (
        .clockin (clockin),
        .reset   (reset),
        .en      (w_busy),
        .load    (bus.load),
        .divisor (bus.divisor),
        .tick    (w_tick),
        .count   (w_count_unused)
    );

`ifdef STEP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdog;

    // Counts cycles of the current request; a completion (including a
    // back-to-back one) starts the next request's count from zero.
    always_ff @(posedge clockin) begin
        if (reset || r_state != REQ || bus.step_done) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    // step_done in the expiry cycle wins over the abort
    assign w_wd_exp = (r_state == REQ) && !bus.step_done &&
                      (r_wdog == WD_W'(TIMEOUT));
`else
    // watchdog not built: REQ waits for step_done indefinitely
    localparam int TIMEOUT_UNUSED = TIMEOUT;
    assign w_wd_exp = 1'b0;
`endif

    // state register plus registered request/overrun
    always_ff @(posedge clockin) begin
        if (reset) begin
            r_state    <= IDLE;
            r_step_req <= 1'b0;
            r_ovr      <= '0;
        end else begin
            r_state    <= w_next;
            // registered from next state so step_req follows tick by 1 cycle
            r_step_req <= (w_next == REQ);
            if (w_ovr_inc) begin
                r_ovr <= OVR_W'(sat_inc(32'(r_ovr), 32'({OVR_W{1'b1}})));
            end
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.single)   w_next = REQ;
                else if (bus.run) w_next = ARMED;
            end
            ARMED: begin
                if (!bus.run)     w_next = IDLE;
                else if (w_tick)  w_next = REQ;
            end
            REQ: begin
                if (bus.step_done) begin
                    // a tick landing on the completion cycle launches the
                    // next step straight away instead of being lost
                    if (bus.run && w_tick) w_next = REQ;
                    else if (bus.run)      w_next = ARMED;
                    else                   w_next = IDLE;
                end else if (w_wd_exp) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // outputs
    always_comb begin
        w_busy    = (r_state != IDLE);
        w_ovr_inc = (r_state == REQ) && w_tick && !bus.step_done;
        w_timeout = w_wd_exp;
    end

    assign bus.step_req    = r_step_req;
    assign bus.tick        = w_tick;
    assign bus.busy        = w_busy;
    assign bus.overrun_cnt = r_ovr;
    assign bus.timeout     = w_timeout;
endmodule
